// File: rtl/cpu_core_if.sv
// Board-side bus of cpu_core: program-memory fetch, push buttons, LED outputs and cycle counter.
// master = CPU side, slave = memory/board side.
interface cpu_core_if #(
   parameter int COUNTER_WIDTH = 24
);
   logic [3:0]               btn;
   logic [7:0]               dout;
   logic [3:0]               pc;
   logic [3:0]               led;
   logic [7:0]               col;
   logic [7:0]               row;
   logic [COUNTER_WIDTH-1:0] counter;

   modport master (
      input  btn, dout,
      output pc, led, col, row, counter
   );

   modport slave (
      output btn, dout,
      input  pc, led, col, row, counter
   );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 8-bit CPU: 4-bit PC, 16-word external program, eight 8-bit registers, LED I/O.
// Optional DEBUG_REGS_EN macro exposes the register file on a debug_regs port.
module cpu_core #(
   parameter int COUNTER_WIDTH = 24
) (
   input  logic        clk,
   input  logic        reset,
   cpu_core_if.master  bus
`ifdef DEBUG_REGS_EN
   ,
   output logic [7:0]  debug_regs [8]
`endif
);
   logic [3:0]               pc_reg;
   logic [7:0]               regs_reg [8];
   logic                     z_reg;
   logic                     c_reg;
   logic [COUNTER_WIDTH-1:0] counter_reg;

   logic [3:0] op;
   logic [3:0] imm;
   logic [2:0] rsel;
   logic [7:0] acc;
   logic [7:0] src;
   logic [8:0] res9;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       flag_we;
   logic [3:0] pc_next;

   assign op   = bus.dout[7:4];
   assign imm  = bus.dout[3:0];
   assign rsel = bus.dout[2:0];
   assign acc  = regs_reg[0];
   assign src  = regs_reg[rsel];

   // res9[8] is the carry/borrow; logic ops leave it zero, which clears C.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 8'h00;
      flag_we = 1'b0;
      res9    = 9'h000;
      pc_next = pc_reg + 4'd1;
      case (op)
         4'h0: begin wr_en = 1'b1; wr_data = {4'h0, imm}; end
         4'h1: begin wr_en = 1'b1; wr_data = {imm, acc[3:0]}; end
         4'h2: begin wr_en = 1'b1; wr_addr = rsel; wr_data = acc; end
         4'h3: begin wr_en = 1'b1; wr_data = src; end
         4'h4: begin res9 = {1'b0, acc} + {1'b0, src}; wr_en = 1'b1; flag_we = 1'b1; end
         4'h5: begin res9 = {1'b0, acc} - {1'b0, src}; wr_en = 1'b1; flag_we = 1'b1; end
         4'h6: begin res9 = {1'b0, acc & src}; wr_en = 1'b1; flag_we = 1'b1; end
         4'h7: begin res9 = {1'b0, acc | src}; wr_en = 1'b1; flag_we = 1'b1; end
         4'h8: begin res9 = {1'b0, acc ^ src}; wr_en = 1'b1; flag_we = 1'b1; end
         4'h9: begin res9 = {1'b0, src} + 9'd1; wr_en = 1'b1; wr_addr = rsel; flag_we = 1'b1; end
         4'hA: begin res9 = {1'b0, src} - 9'd1; wr_en = 1'b1; wr_addr = rsel; flag_we = 1'b1; end
         4'hB: pc_next = imm;
         4'hC: if (z_reg) pc_next = imm;
         4'hD: if (!c_reg) pc_next = imm;
         4'hE: begin wr_en = 1'b1; wr_data = {4'h0, bus.btn}; end
         default: ;
      endcase
      if (flag_we) wr_data = res9[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg      <= 4'd0;
         z_reg       <= 1'b0;
         c_reg       <= 1'b0;
         counter_reg <= '0;
         for (int i = 0; i < 8; i++) regs_reg[i] <= 8'h00;
      end else begin
         pc_reg      <= pc_next;
         counter_reg <= counter_reg + 1'b1;
         if (wr_en) regs_reg[wr_addr] <= wr_data;
         if (flag_we) begin
            z_reg <= (res9[7:0] == 8'h00);
            c_reg <= res9[8];
         end
      end
   end

   assign bus.pc      = pc_reg;
   assign bus.led     = regs_reg[6][3:0];
   assign bus.col     = regs_reg[7];
   assign bus.row     = regs_reg[5];
   assign bus.counter = counter_reg;

`ifdef DEBUG_REGS_EN
   assign debug_regs = regs_reg;
`endif
endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: ISA-level model compared every cycle plus directed literal checks.
module tb_cpu_core;
   localparam int CW = 24;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn = 4'h0;
   logic [7:0] mem [16];
   logic       cmp_en = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   cpu_core_if #(.COUNTER_WIDTH(CW)) bus ();
   assign bus.dout = mem[bus.pc];
   assign bus.btn  = btn;

`ifdef DEBUG_REGS_EN
   logic [7:0] dbg [8];
`endif

   cpu_core #(.COUNTER_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DEBUG_REGS_EN
      ,
      .debug_regs (dbg)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-set model using plain integer arithmetic.
   int m_pc, m_cnt, m_z, m_c;
   int m_r [8];

   always @(posedge clk or posedge reset) begin
      int nr [8];
      int a, b, x, im, np, res, rv, fl, nz, nc;
      logic [7:0] ins;
      if (reset) begin
         m_pc <= 0; m_cnt <= 0; m_z <= 0; m_c <= 0;
         for (int i = 0; i < 8; i++) m_r[i] <= 0;
      end else begin
         nr = m_r; nz = m_z; nc = m_c;
         ins = mem[m_pc];
         x = int'(ins[2:0]); im = int'(ins[3:0]);
         a = m_r[0]; b = m_r[x];
         np = (m_pc + 1) % 16; fl = 0; rv = 0;
         case (int'(ins[7:4]))
            0:  nr[0] = im;
            1:  nr[0] = im * 16 + a % 16;
            2:  nr[x] = a;
            3:  nr[0] = b;
            4:  begin res = a + b; rv = res % 256; nc = (res > 255) ? 1 : 0; nr[0] = rv; fl = 1; end
            5:  begin res = a - b; rv = (res + 256) % 256; nc = (res < 0) ? 1 : 0; nr[0] = rv; fl = 1; end
            6:  begin rv = a & b; nc = 0; nr[0] = rv; fl = 1; end
            7:  begin rv = a | b; nc = 0; nr[0] = rv; fl = 1; end
            8:  begin rv = a ^ b; nc = 0; nr[0] = rv; fl = 1; end
            9:  begin res = b + 1; rv = res % 256; nc = (res > 255) ? 1 : 0; nr[x] = rv; fl = 1; end
            10: begin res = b - 1; rv = (res + 256) % 256; nc = (res < 0) ? 1 : 0; nr[x] = rv; fl = 1; end
            11: np = im;
            12: if (m_z != 0) np = im;
            13: if (m_c == 0) np = im;
            14: nr[0] = int'(btn);
            default: ;
         endcase
         if (fl != 0) nz = (rv == 0) ? 1 : 0;
         m_r <= nr; m_z <= nz; m_c <= nc; m_pc <= np;
         m_cnt <= (m_cnt + 1) % (1 << CW);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc",      32'(bus.pc),      m_pc);
         check("led",     32'(bus.led),     m_r[6] % 16);
         check("col",     32'(bus.col),     m_r[7]);
         check("row",     32'(bus.row),     m_r[5]);
         check("counter", 32'(bus.counter), m_cnt);
      end
   end

   task automatic restart();
      @(negedge clk); #2 reset = 1'b1;
   endtask

   task automatic release_reset();
      @(negedge clk); #2 reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
      // Reset state, before and right after release
      repeat (2) @(negedge clk);
      check("rst_pc",  32'(bus.pc), 0);
      check("rst_led", 32'(bus.led), 0);
      check("rst_col", 32'(bus.col), 0);
      check("rst_row", 32'(bus.row), 0);
      check("rst_cnt", 32'(bus.counter), 0);
      #2 reset = 1'b0;
      #1 check("rel_pc", 32'(bus.pc), 0);
      check("rel_cnt", 32'(bus.counter), 0);
      cmp_en = 1'b1;

      // Basic program, then NOP wrap 15 -> 0
      restart();
      mem = '{8'h01, 8'h26, 8'h90, 8'h90, 8'h21, 8'hBF, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      release_reset();
      repeat (3) @(negedge clk);
      check("basic_pc3", 32'(bus.pc), 3);
      check("basic_led", 32'(bus.led), 1);
      check("model_r0", m_r[0], 2);
      check("model_r6", m_r[6], 1);
      repeat (2) @(negedge clk);
      check("basic_pc5", 32'(bus.pc), 5);
      check("model_r1", m_r[1], 3);
      @(negedge clk); check("jmp_pc15", 32'(bus.pc), 15);
      @(negedge clk); check("wrap_pc0", 32'(bus.pc), 0);

      // Arithmetic and flags
      restart();
      mem = '{8'h0F, 8'h1F, 8'h22, 8'h92, 8'hC8, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h91, 8'h51, 8'hDE, 8'h27, 8'hBD, 8'hFF, 8'hFF};
      release_reset();
      repeat (4) @(negedge clk);
      check("model_r2", m_r[2], 0);
      check("model_z", m_z, 1);
      check("model_c", m_c, 1);
      @(negedge clk); check("jz_taken", 32'(bus.pc), 8);
      repeat (3) @(negedge clk);
      check("sub_r0", m_r[0], 255);
      check("sub_c", m_c, 1);
      @(negedge clk); check("jnc_not_taken", 32'(bus.pc), 12);
      @(negedge clk); check("col_ff", 32'(bus.col), 8'hFF);
      repeat (5) @(negedge clk);
      check("halt_pc", 32'(bus.pc), 13);

      // I/O and logic ops
      restart();
      btn = 4'b1010;
      mem = '{8'hE0, 8'h27, 8'h25, 8'h13, 8'h85, 8'h65, 8'hC9, 8'hFF,
              8'hFF, 8'h0C, 8'h75, 8'h26, 8'hA6, 8'h36, 8'h45, 8'h27};
      release_reset();
      repeat (3) @(negedge clk);
      check("io_col", 32'(bus.col), 8'h0A);
      check("io_row", 32'(bus.row), 8'h0A);
      repeat (4) @(negedge clk); check("and_jz", 32'(bus.pc), 9);
      repeat (3) @(negedge clk); check("or_led", 32'(bus.led), 4'hE);
      @(negedge clk); check("dec_led", 32'(bus.led), 4'hD);
      repeat (3) @(negedge clk);
      check("add_col", 32'(bus.col), 8'h17);
      check("io_wrap", 32'(bus.pc), 0);

      // Async reset mid-run at the halt loop
      restart();
      btn = 4'h0;
      mem = '{8'h05, 8'h26, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB7,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      release_reset();
      repeat (9) @(negedge clk);
      check("halt7_pc", 32'(bus.pc), 7);
      check("halt7_led", 32'(bus.led), 5);
      #2 reset = 1'b1;
      #1 check("async_pc", 32'(bus.pc), 0);
      check("async_led", 32'(bus.led), 0);
      check("async_cnt", 32'(bus.counter), 0);
      release_reset();
      @(negedge clk); check("restart_pc", 32'(bus.pc), 1);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Single-cycle 8-bit-datapath CPU with 4-bit PC, 16-word external instruction memory and eight 8-bit registers.
- Drives 4 board LEDs and an 8x8 LED-matrix column/row pair from dedicated registers.
- Exposes a free-running cycle counter.
- Sits between the program memory (instruction byte fetched at address pc) and the board I/O.

Parameters:
- COUNTER_WIDTH, 24, width of the free-running counter output.

Ports:
- clk  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- btn  in  4  push-button inputs, already synchronised externally.
- dout  in  8  instruction byte at address pc; combinational, valid in the same cycle as pc.
- pc  out  4  program counter / instruction address.
- led  out  4  equals r6[3:0].
- col  out  8  equals r7.
- row  out  8  equals r5.
- counter  out  COUNTER_WIDTH  free-running cycle counter.

Behaviour:
- Reset (async, active-high): pc=0, r0..r7=0, Z=C=0, counter=0. Therefore led=0000, col=00, row=00.
- One instruction retires per rising clk edge; no pipeline, no stalls.
- Decode: op=dout[7:4], imm=dout[3:0], rs/rd=dout[2:0]; dout[3] is ignored for register-field ops.
- Register write and PC update occur on the same edge.
- Default next pc = pc+1; wraps 15 -> 0.
- Opcodes:
  - 0 LDI: r0 = {0000,imm}.
  - 1 LDH: r0 = {imm, r0[3:0]}.
  - 2 MOV rd,r0: rd = r0.
  - 3 MOV r0,rs: r0 = rs.
  - 4 ADD: r0 = r0+rs; C = carry out.
  - 5 SUB: r0 = r0-rs; C = borrow.
  - 6 AND, 7 OR, 8 XOR: r0 = r0 op rs; C cleared.
  - 9 INC rd: rd = rd+1; C = carry out.
  - A DEC rd: rd = rd-1; C = borrow.
  - B JMP: pc = imm.
  - C JZ: pc = imm if Z=1, else pc+1.
  - D JNC: pc = imm if C=0, else pc+1.
  - E IN: r0 = {0000,btn}.
  - F NOP.
- Flags:
  - Z updated only by ops 4..A: Z = (8-bit result == 0).
  - C updated only by ops 4..A.
  - All other ops leave flags unchanged.
- All arithmetic is 8-bit modulo 256 (e.g. INC of FF gives 00 with C=1).
- MOV r0,r0 and rd=rs aliasing are legal; results use pre-edge register values.
- Jump to the current pc is legal and forms a halt loop.
- counter increments by 1 every clk, wraps to 0 at all-ones.
- Asserting reset mid-program clears state immediately. Execution restarts at pc=0 on the first edge after reset deasserts.
- Outputs led/col/row/pc are registered-state derived, with no combinational path from dout.

Optional Feature:
- Macro DEBUG_REGS_EN.
- Defined: adds output port debug_regs, an unpacked array of 8 entries x 8 bits. debug_regs[i] = ri, updated with the register file and reset to 0.
- Undefined: the port does not exist; no other behaviour change.

Test Plan:
- Reset check: hold reset=1 one edge, then release -> pc=0, led=0000, r0=00, r6=00, col=00, row=00, counter=0.
- Basic program: memory 01,26,90,90,21,BF,... ; release reset, then 3 edges -> r0=02, r6=01, led=0001, pc=3. After 2 more edges -> r1=03, pc=5.
- Arithmetic and flags:
  - LDI F, LDH F (r0=FF), MOV r2,r0, INC r2 -> r2=00, Z=1, C=1.
  - A following JZ 8 is taken -> pc=8.
  - SUB of 00-01 -> r0=FF, C=1; JNC is not taken.
- I/O: btn=1010, execute IN then MOV r7,r0 then MOV r5,r0 -> col=0A, row=0A.
- Wrap and halt: NOP sequence advances pc 15 -> 0. JMP to self holds pc constant while counter keeps incrementing.
- Async reset mid-run: assert reset between edges at pc=7 with r6=05 -> pc, led and all registers return to 0 immediately, without waiting for a clk edge.
